// File: rtl/alu_ctrl.sv
// alu_ctrl: two-requester arbiter and sequencer for the shared ALU units.
// One operation is in flight at a time: accept -> issue (one-cycle unit
// enable) -> wait (capture unit_out / unit_flag) -> respond.
// Optional build macro: ALU_CTRL_FIXED_PRIO_EN. When defined, requester 0
// wins every tie and no round-robin pointer exists. Default is round-robin.
// Handshake rule for req0/req1 and rsp: a transfer happens in a cycle where
// valid and ready are both high; the source holds valid and payload stable
// until that cycle.
module alu_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_fun,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_fun,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [3:0]       alu_fun,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             Arith_EN,
  output logic             Logic_EN,
  output logic             CMP_EN,
  output logic             Shift_EN,
  input  logic [WIDTH-1:0] unit_out,
  input  logic [3:0]       unit_flag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       fun_q, fun_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             id_q, id_d;
  // Unit enables, bit order {Shift, CMP, Logic, Arith} to match unit_flag.
  logic [3:0]       en_q, en_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic             busy_q, busy_d;

`ifndef ALU_CTRL_FIXED_PRIO_EN
  // Requester that wins the next tie; 0 out of reset.
  logic             rr_q, rr_d;
`endif

  logic             any_valid;
  logic             win1;
  logic             accept;
  logic [3:0]       sel_fun;
  logic [3:0]       unit_oh;

  // Arbitration: choose the winner and decode the unit of the op in flight.
  always_comb begin
    any_valid = req0_valid | req1_valid;
`ifdef ALU_CTRL_FIXED_PRIO_EN
    win1      = ~req0_valid & req1_valid;
`else
    win1      = (req0_valid & req1_valid) ? rr_q : req1_valid;
`endif
    accept    = (state_q == ST_IDLE) & any_valid;
    sel_fun   = win1 ? req1_fun : req0_fun;
    unit_oh   = 4'b0001 << fun_q[3:2];
  end

  // Ready is gated by rst_n so every output reads 0 while reset is held.
  assign req0_ready = rst_n & accept & ~win1;
  assign req1_ready = rst_n & accept & win1;

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d     = state_q;
    fun_d       = fun_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    en_d        = 4'b0000;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
`ifndef ALU_CTRL_FIXED_PRIO_EN
    rr_d        = rr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_ISSUE;
          fun_d   = sel_fun;
          a_d     = win1 ? req1_a : req0_a;
          b_d     = win1 ? req1_b : req0_b;
          id_d    = win1;
          // Enable is registered so it is high exactly during ISSUE.
          en_d    = 4'b0001 << sel_fun[3:2];
`ifndef ALU_CTRL_FIXED_PRIO_EN
          rr_d    = ~win1;
`endif
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Unit result register is valid in this cycle.
        rsp_data_d  = unit_out;
        rsp_err_d   = (unit_flag != unit_oh);
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      fun_q       <= 4'b0000;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      en_q        <= 4'b0000;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifndef ALU_CTRL_FIXED_PRIO_EN
      rr_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      fun_q       <= fun_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      en_q        <= en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
`ifndef ALU_CTRL_FIXED_PRIO_EN
      rr_q        <= rr_d;
`endif
    end
  end

  assign alu_fun   = fun_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign Arith_EN  = en_q[0];
  assign Logic_EN  = en_q[1];
  assign CMP_EN    = en_q[2];
  assign Shift_EN  = en_q[3];
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: directed scenarios plus randomized two-requester traffic for
// alu_ctrl, checked every cycle against a transaction-level model.
module tb_alu_ctrl;

  localparam int WIDTH = 16;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic [3:0]       req0_fun = 4'h0, req1_fun = 4'h0;
  logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]       alu_fun;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic             Arith_EN, Logic_EN, CMP_EN, Shift_EN;
  logic [WIDTH-1:0] unit_out;
  logic [3:0]       unit_flag;
  logic             rsp_valid, rsp_id, rsp_err, busy;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_data;
  logic [3:0]       en_vec;
  logic [3:0]       force_flag = 4'h0;

  assign en_vec = {Shift_EN, CMP_EN, Logic_EN, Arith_EN};

  alu_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_fun(req0_fun),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_fun(req1_fun),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_fun(alu_fun), .alu_a(alu_a), .alu_b(alu_b),
    .Arith_EN(Arith_EN), .Logic_EN(Logic_EN), .CMP_EN(CMP_EN), .Shift_EN(Shift_EN),
    .unit_out(unit_out), .unit_flag(unit_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  // ---------------- counters / compare helper ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- ALU unit environment ----------------
  function automatic logic [15:0] alu_func(input logic [3:0] f, input logic [15:0] a,
                                           input logic [15:0] b);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    case (f)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return p[15:0];
      4'h3: return b - a;
      4'h4: return a & b;
      4'h5: return a | b;
      4'h6: return a ^ b;
      4'h7: return ~(a & b);
      4'h8: return {15'd0, a == b};
      4'h9: return (a > b) ? 16'd2 : 16'd0;
      4'hA: return (a < b) ? 16'd3 : 16'd0;
      4'hB: return (a != b) ? 16'd4 : 16'd0;
      4'hC: return a >> 1;
      4'hD: return a << 1;
      4'hE: return {a[0], a[15:1]};
      default: return {a[14:0], a[15]};
    endcase
  endfunction

  // Operand patterns that make the unit report a wrong flag.
  function automatic bit corrupt(input logic [15:0] a, input logic [15:0] b);
    return (32'(a ^ b) % 5) == 0;
  endfunction

  // Unit registers: result and flag appear the cycle after an enable, else 0.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unit_out  <= '0;
      unit_flag <= 4'h0;
    end else if (en_vec != 4'h0) begin
      unit_out  <= alu_func(alu_fun, alu_a, alu_b);
      if (force_flag != 4'h0)          unit_flag <= force_flag;
      else if (corrupt(alu_a, alu_b))  unit_flag <= {en_vec[2:0], en_vec[3]};
      else                             unit_flag <= en_vec;
    end else begin
      unit_out  <= '0;
      unit_flag <= 4'h0;
    end
  end

  // ---------------- reference model + compare process ----------------
  bit               m_have = 1'b0;
  int               m_age  = 0;
  bit               m_last = 1'b1;
  bit               m_id   = 1'b0;
  bit               m_err  = 1'b0;
  logic [3:0]       m_fun  = 4'h0;
  logic [WIDTH-1:0] m_a = '0, m_b = '0, m_res = '0;

  always @(negedge clk) begin : compare
    logic [3:0] exp_en;
    logic [3:0] oh;
    bit         exp_r0, exp_r1, w1, rv;
    if (!rst_n) begin
      m_have = 1'b0; m_age = 0; m_last = 1'b1;
      m_fun = 4'h0; m_a = '0; m_b = '0;
      chk("rst_busy", busy, 0);
      chk("rst_enables", en_vec, 0);
      chk("rst_ready", {req1_ready, req0_ready}, 0);
      chk("rst_rsp", {rsp_valid, rsp_id, rsp_err}, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_alu_fun", alu_fun, 0);
      chk("rst_alu_ab", {alu_a, alu_b}, 0);
    end else begin
      exp_r0 = 1'b0; exp_r1 = 1'b0; w1 = 1'b0; exp_en = 4'h0;
      if (!m_have && (req0_valid || req1_valid)) begin
`ifdef ALU_CTRL_FIXED_PRIO_EN
        w1 = !req0_valid;
`else
        w1 = (req0_valid && req1_valid) ? !m_last : req1_valid;
`endif
        exp_r0 = !w1;
        exp_r1 = w1;
      end
      if (m_have && m_age == 1) exp_en = 4'b0001 << m_fun[3:2];
      rv = m_have && (m_age >= 3);
      chk("busy", busy, m_have);
      chk("req0_ready", req0_ready, exp_r0);
      chk("req1_ready", req1_ready, exp_r1);
      chk("enables", en_vec, exp_en);
      chk("alu_fun", alu_fun, m_fun);
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("rsp_valid", rsp_valid, rv);
      if (rv) begin
        chk("rsp_data", rsp_data, m_res);
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_err", rsp_err, m_err);
      end
      if (m_have) begin
        if (m_age >= 3 && rsp_ready) m_have = 1'b0;
        else m_age++;
      end else if (exp_r0 || exp_r1) begin
        m_have = 1'b1;
        m_age  = 1;
        m_id   = w1;
        m_last = w1;
        m_fun  = w1 ? req1_fun : req0_fun;
        m_a    = w1 ? req1_a : req0_a;
        m_b    = w1 ? req1_b : req0_b;
        m_res  = alu_func(m_fun, m_a, m_b);
        oh     = 4'b0001 << m_fun[3:2];
        m_err  = (force_flag != 4'h0) ? (force_flag != oh) : corrupt(m_a, m_b);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(tag, busy, 0);
  endtask

  task automatic req_run(input bit id, input int n_ops);
    for (int k = 0; k < n_ops; k++) begin
      int gap;
      int waited;
      bit got;
      gap = $urandom_range(0, 3);
      repeat (gap) @(posedge clk);
      @(posedge clk);
      #2;
      if (!id) begin
        req0_valid = 1'b1;
        req0_fun   = 4'($urandom_range(0, 15));
        req0_a     = 16'($urandom);
        req0_b     = 16'($urandom);
      end else begin
        req1_valid = 1'b1;
        req1_fun   = 4'($urandom_range(0, 15));
        req1_a     = 16'($urandom);
        req1_b     = 16'($urandom);
      end
      waited = 0;
      got    = 1'b0;
      while (!got && waited < 200) begin
        @(negedge clk);
        waited++;
        got = id ? req1_ready : req0_ready;
      end
      chk(id ? "req1_handshake" : "req0_handshake", got, 1);
      @(posedge clk);
      #2;
      if (!id) req0_valid = 1'b0;
      else     req1_valid = 1'b0;
    end
  endtask

  // ---------------- main sequence ----------------
  int order [4];
  int gcyc  [4];
  int ng, cyc, exp_g;
  bit got, rand_done;

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    // Reset values.
    chk("reset_busy", busy, 0);
    chk("reset_enables", en_vec, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_alu_fun", alu_fun, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Contention: both requesters valid, rsp_ready high.
    @(posedge clk); #2;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_fun = 4'h4; req0_a = 16'h1234; req0_b = 16'h0F0F;
    req1_valid = 1'b1; req1_fun = 4'h9; req1_a = 16'h0100; req1_b = 16'h00FF;
    for (int i = 0; i < 4; i++) begin order[i] = -1; gcyc[i] = 0; end
    ng = 0; cyc = 0;
    while (ng < 4 && cyc < 40) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        order[ng] = int'(req1_ready);
        gcyc[ng]  = cyc;
        ng++;
      end
      cyc++;
    end
    chk("contention_grants", ng, 4);
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_CTRL_FIXED_PRIO_EN
      exp_g = 0;
`else
      exp_g = i % 2;
`endif
      chk("grant_order", order[i], exp_g);
      if (i > 0) chk("grant_spacing", gcyc[i] - gcyc[i-1], 4);
    end
    @(posedge clk); #2;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle("contention_idle");

    // Single op: shift-left of 4 gives 8 with Shift flag.
    @(posedge clk); #2;
    req0_valid = 1'b1; req0_fun = 4'b1101; req0_a = 16'h0004; req0_b = 16'h0003;
    #2 chk("single_ready", req0_ready, 1);
    @(posedge clk); #2;
    req0_valid = 1'b0;
    chk("single_shift_en", en_vec, 4'b1000);
    @(posedge clk); #2;
    chk("single_c2_no_valid", rsp_valid, 0);
    chk("single_c2_en_low", en_vec, 0);
    @(posedge clk); #2;
    chk("single_rsp_valid", rsp_valid, 1);
    chk("single_rsp_data", rsp_data, 16'h0008);
    chk("single_rsp_id", rsp_id, 0);
    chk("single_rsp_err", rsp_err, 0);
    wait_idle("single_idle");

    // Backpressure: 0x00F0 | 0x0F00 = 0x0FF0, operands hit the bad-flag pattern.
    @(posedge clk); #2;
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_fun = 4'b0101; req1_a = 16'h00F0; req1_b = 16'h0F00;
    #2 chk("bp_accept", req1_ready, 1);
    @(posedge clk); #2;
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_fun = 4'h0; req0_a = 16'h0001; req0_b = 16'h0002;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #4;
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_data", rsp_data, 16'h0FF0);
      chk("bp_rsp_id", rsp_id, 1);
      chk("bp_rsp_err", rsp_err, 1);
      chk("bp_no_ready", {req1_ready, req0_ready}, 0);
    end
    @(posedge clk); #2;
    rsp_ready = 1'b1;
    #2 chk("bp_release_valid", rsp_valid, 1);
    @(posedge clk); #2;
    chk("bp_idle_busy", busy, 0);
    chk("bp_next_accept", req0_ready, 1);
    @(posedge clk); #2;
    req0_valid = 1'b0;
    wait_idle("bp_idle");

    // Flag error: add with a CMP flag returned.
    force_flag = 4'b0100;
    @(posedge clk); #2;
    req0_valid = 1'b1; req0_fun = 4'b0000; req0_a = 16'h0011; req0_b = 16'h0022;
    #2 chk("flag_accept", req0_ready, 1);
    @(posedge clk); #2;
    req0_valid = 1'b0;
    #2 chk("flag_only_arith", en_vec, 4'b0001);
    @(posedge clk); #4;
    chk("flag_c2_en_low", en_vec, 0);
    @(posedge clk); #4;
    chk("flag_rsp_valid", rsp_valid, 1);
    chk("flag_rsp_err", rsp_err, 1);
    chk("flag_rsp_data", rsp_data, 16'h0033);
    wait_idle("flag_idle");
    force_flag = 4'h0;

    // Reset in WAIT with both requesters pending.
    @(posedge clk); #2;
    req0_valid = 1'b1; req0_fun = 4'b0110; req0_a = 16'h0005; req0_b = 16'h0006;
    #2 chk("mid_accept", req0_ready, 1);
    @(posedge clk); #2;
    req0_fun = 4'b0010; req0_a = 16'h0007; req0_b = 16'h0009;
    req1_valid = 1'b1; req1_fun = 4'b1100; req1_a = 16'h8001; req1_b = 16'h0000;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_en", en_vec, 0);
    chk("mid_rst_ready", {req1_ready, req0_ready}, 0);
    chk("mid_rst_rsp", {rsp_valid, rsp_id, rsp_err}, 0);
    chk("mid_rst_data", rsp_data, 0);
    chk("mid_rst_alu", {alu_fun, alu_a, alu_b}, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    #2;
    chk("mid_post_ready0", req0_ready, 1);
    chk("mid_post_ready1", req1_ready, 0);
    @(posedge clk); #2;
    req0_valid = 1'b0;
    got = 1'b0; cyc = 0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      got = req1_ready;
      cyc++;
    end
    chk("mid_req1_grant", got, 1);
    @(posedge clk); #2;
    req1_valid = 1'b0;
    wait_idle("mid_idle");

    // Randomized traffic from both requesters with random backpressure.
    rand_done = 1'b0;
    fork
      begin
        fork
          req_run(1'b0, 25);
          req_run(1'b1, 25);
        join
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #2;
          rsp_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    @(posedge clk); #2;
    rsp_ready = 1'b1;
    wait_idle("drain_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
